// File: rtl/t07_mem_arbiter.sv
// Multi-channel arbiter for the shared external memory bus (rwi/busy handshake).
// Define T07_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority otherwise.
module t07_mem_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  localparam int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [NUM_CH-1:0]        req_i,
  input  logic [NUM_CH-1:0]        we_i,
  input  logic [NUM_CH*ADDR_W-1:0] addr_i,
  input  logic [NUM_CH*DATA_W-1:0] wdata_i,
  output logic [NUM_CH-1:0]        done_o,
  output logic [NUM_CH-1:0]        err_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic [ID_W-1:0]          gnt_id_o,
  output logic [1:0]               rwi_o,
  output logic [ADDR_W-1:0]        addr_o,
  output logic [DATA_W-1:0]        wdata_o,
  input  logic [DATA_W-1:0]        rdata_i,
  input  logic                     busy_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state_q;
  state_t           state_d;
  logic             any_req;
  logic [ID_W-1:0]  win_id;
  logic [ID_W-1:0]  id_q;
  logic             we_q;
  logic [CNT_W-1:0] cnt_q;
  logic [NUM_CH-1:0] err_q;
  logic             waiting;
  logic             timeout_hit;
  int               idx;

  assign gnt_id_o = id_q;
  assign err_o    = err_q;

  // The counter only advances while the handshake is stalled in ISSUE or WAIT.
  assign waiting     = ((state_q == ISSUE) && !busy_i) || ((state_q == WAIT) && busy_i);
  assign timeout_hit = waiting && (cnt_q == CNT_W'(TIMEOUT - 1));

`ifdef T07_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr_q;

  // Scan downward so the requestor closest to the pointer is assigned last and wins.
  always_comb begin
    any_req = 1'b0;
    win_id  = '0;
    idx     = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (req_i[idx]) begin
        any_req = 1'b1;
        win_id  = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rr_ptr_q <= '0;
    end else if ((state_q == IDLE) && any_req) begin
      rr_ptr_q <= (win_id == ID_W'(NUM_CH - 1)) ? '0 : win_id + 1'b1;
    end
  end
`else
  always_comb begin
    any_req = 1'b0;
    win_id  = '0;
    idx     = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = i;
      if (req_i[idx]) begin
        any_req = 1'b1;
        win_id  = ID_W'(idx);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   if (busy_i) state_d = WAIT;
               else if (timeout_hit) state_d = IDLE;
      WAIT:    if (!busy_i) state_d = DONE;
               else if (timeout_hit) state_d = IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rwi_o  = 2'b00;
    done_o = '0;
    if (state_q == ISSUE) rwi_o = we_q ? 2'b01 : 2'b10;
    for (int k = 0; k < NUM_CH; k++) begin
      done_o[k] = (state_q == DONE) && (id_q == ID_W'(k));
    end
  end

  // Only the winner's inputs are captured; later changes on any channel never reach the bus.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_o  <= '0;
      wdata_o <= '0;
      rdata_o <= '0;
      we_q    <= 1'b0;
      id_q    <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      if ((state_q == IDLE) && any_req) begin
        addr_o  <= addr_i[win_id*ADDR_W +: ADDR_W];
        wdata_o <= wdata_i[win_id*DATA_W +: DATA_W];
        we_q    <= we_i[win_id];
        id_q    <= win_id;
      end
      if (state_d != state_q)   cnt_q <= '0;
      else if (waiting)         cnt_q <= cnt_q + 1'b1;
      if ((state_q == WAIT) && !busy_i && !we_q) rdata_o <= rdata_i;
      for (int k = 0; k < NUM_CH; k++) begin
        err_q[k] <= timeout_hit && (id_q == ID_W'(k));
      end
    end
  end

endmodule

// File: tb/tb_t07_mem_arbiter.sv
// Directed self-checking bench for t07_mem_arbiter (2 channels, TIMEOUT=8).
// Expected grant order follows T07_ARB_ROUND_ROBIN_EN when it is defined.
module tb_t07_mem_arbiter;

  logic        clk;
  logic        nrst;
  logic [1:0]  req_i;
  logic [1:0]  we_i;
  logic [63:0] addr_i;
  logic [63:0] wdata_i;
  logic [1:0]  done_o;
  logic [1:0]  err_o;
  logic [31:0] rdata_o;
  logic [0:0]  gnt_id_o;
  logic [1:0]  rwi_o;
  logic [31:0] addr_o;
  logic [31:0] wdata_o;
  logic [31:0] rdata_i;
  logic        busy_i;

  int checks   = 0;
  int failures = 0;

  int          ticks_seen;
  logic [1:0]  rwi_seen;
  logic [0:0]  gnt_seen;
  logic [31:0] addr_seen;
  logic [31:0] wdata_seen;
  logic [31:0] addr_wait;
  logic [1:0]  rwi_wait;
  logic [1:0]  done_seen;
  logic [1:0]  err_seen;
  logic [31:0] rdata_seen;
  int          exp_gnt[4];

  t07_mem_arbiter #(
    .NUM_CH (2),
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(8)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .req_i   (req_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .done_o  (done_o),
    .err_o   (err_o),
    .rdata_o (rdata_o),
    .gnt_id_o(gnt_id_o),
    .rwi_o   (rwi_o),
    .addr_o  (addr_o),
    .wdata_o (wdata_o),
    .rdata_i (rdata_i),
    .busy_i  (busy_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apply_stimulus(input int ch, input logic we, input logic [31:0] a, input logic [31:0] wd);
    req_i[ch]            = 1'b1;
    we_i[ch]             = we;
    addr_i[ch*32 +: 32]  = a;
    wdata_i[ch*32 +: 32] = wd;
  endtask

  // Acts as the external memory for one transaction: busy rises one cycle after
  // the command appears and stays high for busy_len cycles.
  task automatic serve(input int busy_len, input logic [31:0] rd, input int drop_ch);
    bit found;
    found      = 1'b0;
    ticks_seen = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      ticks_seen++;
      if (rwi_o != 2'b00) found = 1'b1;
    end
    check_output("command_seen", 64'(found), 64'd1);
    if (found) begin
      rwi_seen   = rwi_o;
      gnt_seen   = gnt_id_o;
      addr_seen  = addr_o;
      wdata_seen = wdata_o;
      if (drop_ch >= 0) begin
        req_i[drop_ch]           = 1'b0;
        we_i[drop_ch]            = ~we_i[drop_ch];
        addr_i[drop_ch*32 +: 32] = 32'hFFFF_FFF0;
      end
      tick();
      ticks_seen++;
      busy_i  = 1'b1;
      rdata_i = 32'h0BAD_F00D;
      for (int j = 0; j < busy_len; j++) begin
        tick();
        ticks_seen++;
      end
      addr_wait = addr_o;
      rwi_wait  = rwi_o;
      busy_i    = 1'b0;
      rdata_i   = rd;
      tick();
      ticks_seen++;
      done_seen  = done_o;
      err_seen   = err_o;
      rdata_seen = rdata_o;
    end
  endtask

  initial begin
`ifdef T07_ARB_ROUND_ROBIN_EN
    exp_gnt = '{0, 1, 0, 1};
`else
    exp_gnt = '{0, 0, 0, 0};
`endif
    nrst    = 1'b0;
    req_i   = '0;
    we_i    = '0;
    addr_i  = '0;
    wdata_i = '0;
    rdata_i = '0;
    busy_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_rwi",   64'(rwi_o),    64'h0);
    check_output("reset_addr",  64'(addr_o),   64'h0);
    check_output("reset_wdata", 64'(wdata_o),  64'h0);
    check_output("reset_rdata", 64'(rdata_o),  64'h0);
    check_output("reset_done",  64'(done_o),   64'h0);
    check_output("reset_err",   64'(err_o),    64'h0);
    check_output("reset_gnt",   64'(gnt_id_o), 64'h0);
    nrst = 1'b1;
    tick();

    // Contention: both channels hold their requests across four transactions.
    apply_stimulus(0, 1'b0, 32'h0000_0100, 32'h0);
    apply_stimulus(1, 1'b1, 32'h0000_0200, 32'hAAAA_5555);
    for (int k = 0; k < 4; k++) begin
      serve(2, 32'h1000_0000 + 32'(k), -1);
      check_output($sformatf("cont_gnt%0d", k),  64'(gnt_seen),  64'(exp_gnt[k]));
      check_output($sformatf("cont_rwi%0d", k),  64'(rwi_seen),  (exp_gnt[k] == 1) ? 64'h1 : 64'h2);
      check_output($sformatf("cont_done%0d", k), 64'(done_seen), 64'h1 << exp_gnt[k]);
      check_output($sformatf("cont_err%0d", k),  64'(err_seen),  64'h0);
      check_output($sformatf("cont_lat%0d", k),  64'(ticks_seen), (k == 0) ? 64'd5 : 64'd6);
    end
    req_i = '0;
    tick();
    check_output("cont_done_off", 64'(done_o), 64'h0);

    // Single read on channel 0.
    apply_stimulus(0, 1'b0, 32'h0000_1000, 32'h0);
    serve(2, 32'hDEAD_BEEF, -1);
    check_output("rd_rwi",   64'(rwi_seen),   64'h2);
    check_output("rd_addr",  64'(addr_seen),  64'h1000);
    check_output("rd_gnt",   64'(gnt_seen),   64'h0);
    check_output("rd_wait_rwi", 64'(rwi_wait), 64'h0);
    check_output("rd_done",  64'(done_seen),  64'h1);
    check_output("rd_err",   64'(err_seen),   64'h0);
    check_output("rd_rdata", 64'(rdata_seen), 64'hDEAD_BEEF);
    check_output("rd_lat",   64'(ticks_seen), 64'd5);
    req_i = '0;
    tick();
    check_output("rd_done_off", 64'(done_o), 64'h0);

    // Single write on channel 1; read data must not change.
    apply_stimulus(1, 1'b1, 32'h0000_2004, 32'h1234_5678);
    serve(2, 32'hBAD0_BAD0, -1);
    check_output("wr_rwi",   64'(rwi_seen),   64'h1);
    check_output("wr_addr",  64'(addr_seen),  64'h2004);
    check_output("wr_wdata", 64'(wdata_seen), 64'h1234_5678);
    check_output("wr_gnt",   64'(gnt_seen),   64'h1);
    check_output("wr_done",  64'(done_seen),  64'h2);
    check_output("wr_rdata", 64'(rdata_seen), 64'hDEAD_BEEF);
    req_i = '0;
    tick();
    check_output("wr_done_off", 64'(done_o), 64'h0);

    // Timeout: busy never rises, so the abort follows 8 ISSUE cycles.
    apply_stimulus(0, 1'b0, 32'h0000_4000, 32'h0);
    repeat (8) tick();
    check_output("to_still_issue", 64'(rwi_o), 64'h2);
    check_output("to_no_err_yet",  64'(err_o), 64'h0);
    tick();
    check_output("to_err",  64'(err_o),  64'h1);
    check_output("to_done", 64'(done_o), 64'h0);
    check_output("to_rwi",  64'(rwi_o),  64'h0);
    req_i = '0;
    tick();
    check_output("to_err_off", 64'(err_o), 64'h0);
    check_output("to_idle_rwi", 64'(rwi_o), 64'h0);

    // Request dropped right after grant, minimum-latency handshake.
    apply_stimulus(0, 1'b0, 32'h0000_5000, 32'h0);
    serve(1, 32'h600D_CAFE, 0);
    check_output("drop_addr_held", 64'(addr_wait),  64'h5000);
    check_output("drop_done",      64'(done_seen),  64'h1);
    check_output("drop_rdata",     64'(rdata_seen), 64'h600D_CAFE);
    check_output("drop_lat",       64'(ticks_seen), 64'd4);
    tick();
    check_output("drop_done_off", 64'(done_o), 64'h0);
    check_output("drop_no_regrant", 64'(rwi_o), 64'h0);

    // Reset asserted while the bus is busy in WAIT.
    apply_stimulus(1, 1'b0, 32'h0000_3000, 32'h0);
    tick();
    check_output("mid_issue_rwi", 64'(rwi_o), 64'h2);
    tick();
    busy_i = 1'b1;
    tick();
    tick();
    check_output("mid_wait_rwi", 64'(rwi_o), 64'h0);
    nrst = 1'b0;
    #1;
    check_output("mid_rst_rwi",   64'(rwi_o),    64'h0);
    check_output("mid_rst_addr",  64'(addr_o),   64'h0);
    check_output("mid_rst_rdata", 64'(rdata_o),  64'h0);
    check_output("mid_rst_gnt",   64'(gnt_id_o), 64'h0);
    check_output("mid_rst_dmerr", 64'({done_o, err_o}), 64'h0);
    req_i  = '0;
    busy_i = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
    tick();
    apply_stimulus(1, 1'b0, 32'h0000_3008, 32'h0);
    serve(2, 32'hCAFE_F00D, -1);
    check_output("post_rst_gnt",   64'(gnt_seen),   64'h1);
    check_output("post_rst_addr",  64'(addr_seen),  64'h3008);
    check_output("post_rst_done",  64'(done_seen),  64'h2);
    check_output("post_rst_rdata", 64'(rdata_seen), 64'hCAFE_F00D);
    req_i = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
